// File: rtl/imem_arbiter.sv
// Fetch/loader arbiter for the single-port instruction memory.
// Fetch has priority; starvation counter and lock mode let the loader through.
module imem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned MEM_WORDS  = 'h20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  output logic        f_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_lock,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_en,
  output logic        m_we,
  output logic [16:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  localparam logic [3:0]  SMAX = 4'(STARVE_MAX);
  localparam logic [29:0] WLIM = 30'(MEM_WORDS);

  typedef enum logic {NORMAL, LOCKED} state_t;

  state_t      state, state_n;
  logic [3:0]  starve, starve_n;
  logic        pend, owner, rbad;
  logic        f_bad, d_bad;
  logic        rd_gnt, gnt_bad;

  assign f_bad = (|f_addr[1:0]) || (f_addr[31:2] >= WLIM);
  assign d_bad = (|d_addr[1:0]) || (d_addr[31:2] >= WLIM);

  always_comb begin
    f_gnt    = 1'b0;
    d_gnt    = 1'b0;
    state_n  = state;
    starve_n = starve;
    unique case (state)
      NORMAL: begin
        if (d_req && starve == SMAX) d_gnt = 1'b1;
        else if (f_req)              f_gnt = 1'b1;
        else if (d_req)              d_gnt = 1'b1;
        if (d_gnt && d_lock) state_n = LOCKED;
      end
      LOCKED: begin
        d_gnt = d_req;
        // d_gnt mirrors d_req here, so both exit conditions reduce to !d_lock
        if (!d_lock) state_n = NORMAL;
      end
    endcase
    if (state == LOCKED || d_gnt || !d_req) starve_n = 4'd0;
    else if (starve != SMAX)                starve_n = starve + 4'd1;
  end

  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = 17'd0;
    m_wdata = 32'd0;
    if (d_gnt) begin
      m_wdata = d_wdata;
      if (!d_bad) begin
        m_en   = 1'b1;
        m_we   = d_we;
        m_addr = d_addr[18:2];
      end
    end else if (f_gnt && !f_bad) begin
      m_en   = 1'b1;
      m_addr = f_addr[18:2];
    end
  end

  assign rd_gnt  = f_gnt | (d_gnt & ~d_we);
  assign gnt_bad = d_gnt ? d_bad : f_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= NORMAL;
      starve <= 4'd0;
      pend   <= 1'b0;
      owner  <= 1'b0;
      rbad   <= 1'b0;
    end else begin
      state  <= state_n;
      starve <= starve_n;
      pend   <= rd_gnt;
      owner  <= d_gnt;
      rbad   <= rd_gnt & gnt_bad;
    end
  end

  assign f_rvalid = pend & ~owner;
  assign d_rvalid = pend & owner;
  assign f_err    = f_rvalid & rbad;
  assign d_err    = (d_rvalid & rbad) | (d_gnt & d_we & d_bad);
  assign f_rdata  = (f_rvalid && !rbad) ? m_rdata : 32'd0;
  assign d_rdata  = (d_rvalid && !rbad) ? m_rdata : 32'd0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural one-cycle memory.
// Expected values are hand-computed per scenario.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, f_gnt, f_rvalid, f_err;
  logic [31:0] f_addr, f_rdata;
  logic        d_req, d_we, d_lock, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_en, m_we;
  logic [16:0] m_addr;
  logic [31:0] m_wdata, m_rdata;

  logic [31:0] mem [0:'h1FFFF];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  imem_arbiter #(.STARVE_MAX(4), .MEM_WORDS('h20000)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata <= mem[m_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in;
    f_req = 0; f_addr = 0;
    d_req = 0; d_we = 0; d_lock = 0; d_addr = 0; d_wdata = 0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rv"}, {30'd0, f_rvalid, d_rvalid}, 32'd0);
    chk({tag, "_err"}, {30'd0, f_err, d_err}, 32'd0);
    chk({tag, "_frd"}, f_rdata, 32'd0);
    chk({tag, "_drd"}, d_rdata, 32'd0);
    chk({tag, "_m"}, {13'd0, m_en, m_we, m_addr}, 32'd0);
    chk({tag, "_mwd"}, m_wdata, 32'd0);
  endtask

  initial begin
    int w;
    for (int i = 0; i < 'h20000; i++) mem[i] = 32'd0;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
    m_rdata = 32'd0;
    idle_in();
    rst_n = 1'b0;
    #12;
    chk_reset_outs("rst");
    rst_n = 1'b1;
    tick();

    // fetch-only stream
    for (int i = 0; i < 3; i++) begin
      f_req = 1; f_addr = 32'(4 * i);
      #1;
      chk("fs_gnt", {31'd0, f_gnt}, 32'd1);
      chk("fs_men", {31'd0, m_en}, 32'd1);
      chk("fs_addr", {15'd0, m_addr}, 32'(i));
      if (i > 0) begin
        chk("fs_rv", {31'd0, f_rvalid}, 32'd1);
        chk("fs_rd", f_rdata, 32'(17 * i));
      end
      tick();
    end
    f_req = 0;
    #1;
    chk("fs_rv", {31'd0, f_rvalid}, 32'd1);
    chk("fs_rd3", f_rdata, 32'h33);
    tick();

    // contention with starvation
    f_req = 1; f_addr = 32'h4;
    d_req = 1; d_we = 0; d_addr = 32'h0;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("ct_f%0d", c), {31'd0, f_gnt}, {31'd0, c % 5 != 4});
      chk($sformatf("ct_d%0d", c), {31'd0, d_gnt}, {31'd0, c % 5 == 4});
      if (c == 5) begin
        chk("ct_drv", {31'd0, d_rvalid}, 32'd1);
        chk("ct_drd", d_rdata, 32'h11);
        chk("ct_frd", f_rdata, 32'd0);
      end
      tick();
    end
    idle_in();
    tick();

    // lock burst
    f_req = 1; f_addr = 32'h0;
    d_req = 1; d_we = 1; d_lock = 1;
    d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    w = 0;
    #1;
    while (!d_gnt && w < 10) begin
      tick();
      #1;
      w++;
    end
    chk("lk_wait", 32'(w), 32'd4);
    tick();
    d_addr = 32'h104;
    #1;
    chk("lk_fg", {31'd0, f_gnt}, 32'd0);
    chk("lk_dg", {31'd0, d_gnt}, 32'd1);
    chk("lk_m", {14'd0, m_en, m_we, m_addr}, {14'd0, 2'b11, 17'h41});
    tick();
    d_addr = 32'h108; d_wdata = 32'hCAFEF00D; d_lock = 0;
    #1;
    chk("lk_fg2", {31'd0, f_gnt}, 32'd0);
    chk("lk_dg2", {31'd0, d_gnt}, 32'd1);
    tick();
    d_req = 0; d_we = 0;
    #1;
    chk("lk_back", {31'd0, f_gnt}, 32'd1);
    tick();
    f_req = 0; d_req = 1; d_addr = 32'h104;
    #1;
    chk("rb_gnt", {31'd0, d_gnt}, 32'd1);
    tick();
    d_req = 0;
    #1;
    chk("rb_rv", {30'd0, f_rvalid, d_rvalid}, 32'd1);
    chk("rb_rd", d_rdata, 32'hDEADBEEF);
    tick();

    // misaligned fetch
    f_req = 1; f_addr = 32'h6;
    #1;
    chk("mis_gnt", {31'd0, f_gnt}, 32'd1);
    chk("mis_men", {31'd0, m_en}, 32'd0);
    tick();
    f_req = 0;
    #1;
    chk("mis_rv", {30'd0, f_rvalid, f_err}, 32'd3);
    chk("mis_rd", f_rdata, 32'd0);
    tick();

    // out-of-range loader write
    d_req = 1; d_we = 1; d_addr = 32'h80000; d_wdata = 32'h12345678;
    #1;
    chk("oor_gnt", {31'd0, d_gnt}, 32'd1);
    chk("oor_err", {31'd0, d_err}, 32'd1);
    chk("oor_men", {31'd0, m_en}, 32'd0);
    tick();
    idle_in();
    #1;
    chk("oor_mem", mem[0], 32'h11);
    chk("oor_after", {30'd0, d_err, d_rvalid}, 32'd0);
    tick();

    // reset mid-read
    f_req = 1; f_addr = 32'h8;
    #1;
    chk("mr_gnt", {31'd0, f_gnt}, 32'd1);
    #1;
    rst_n = 1'b0;
    f_req = 0;
    #1;
    chk_reset_outs("mr_in");
    tick();
    rst_n = 1'b1;
    #1;
    chk_reset_outs("mr_rel");
    tick();
    chk("mr_late", {31'd0, f_rvalid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-requester arbiter and sequencer for the single-port, word-addressed instruction memory. The CPU fetch stage and a debug/program loader share one memory port. The block grants at most one access per cycle and translates byte addresses to word indices. It routes one-cycle-latency read data back to the requester that issued the read. Fetch has priority; a starvation counter and a lock mode guarantee loader progress during program download.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive denied loader cycles before the loader is forced a grant; legal range 1..15.
- MEM_WORDS, 'h20000: memory depth in words; word index width is 17.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- f_req  in  1  fetch read request
- f_addr  in  32  fetch byte address
- f_gnt  out  1  fetch request accepted this cycle (combinational)
- f_rvalid  out  1  fetch read data valid (registered)
- f_rdata  out  32  fetch read data
- f_err  out  1  with f_rvalid: access was misaligned or out of range
- d_req  in  1  loader request
- d_we  in  1  loader write (1) / read (0)
- d_lock  in  1  loader holds the port after its next grant
- d_addr  in  32  loader byte address
- d_wdata  in  32  loader write data
- d_gnt  out  1  loader request accepted this cycle (combinational)
- d_rvalid  out  1  loader read data valid (registered)
- d_rdata  out  32  loader read data
- d_err  out  1  with d_rvalid or d_gnt-on-write: access was misaligned or out of range
- m_en  out  1  memory access enable
- m_we  out  1  memory write enable
- m_addr  out  17  word index = byte address >> 2
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data, valid the cycle after m_en & !m_we

## Operation
- States: NORMAL and LOCKED. Starvation counter `starve` is 4 bits wide.
- In NORMAL, the grant rules apply in this order:
  - If d_req and starve == STARVE_MAX: d_gnt = 1.
  - Else if f_req: f_gnt = 1.
  - Else if d_req: d_gnt = 1.
- In LOCKED: f_gnt = 0 always; d_gnt = d_req.
- NORMAL -> LOCKED on a cycle with d_gnt & d_lock.
- LOCKED -> NORMAL on a cycle with d_gnt & !d_lock, or on a cycle with !d_req & !d_lock.
- Starvation counter:
  - Cleared when d_gnt = 1 or d_req = 0.
  - Otherwise incremented, saturating at STARVE_MAX.
  - Held at 0 in LOCKED.
- Address check: an access is bad if addr[1:0] != 0 or addr[31:2] >= MEM_WORDS.
- A bad access is still granted, but m_en = 0 for that cycle:
  - A bad read returns rvalid = 1 next cycle with rdata = 0 and err = 1.
  - A bad write asserts d_err in the grant cycle only.
- Good granted access: m_en = 1, m_addr = addr[18:2], and m_we = d_we for the loader (always 0 for fetch). m_wdata = d_wdata whenever the loader is granted, otherwise 0.
- Read return:
  - A 1-bit owner register plus a pending flag record every granted read.
  - The next cycle, the owner's rvalid = 1 and its rdata = m_rdata (0 if bad); the other port's rdata = 0.
- Simultaneous f_req and d_req with starve < STARVE_MAX: fetch wins and starve increments.

## Timing
- Reset values (async on rst_n = 0):
  - State NORMAL; starve = 0; pending = 0.
  - f_rvalid, d_rvalid, f_err, d_err = 0; rdata outputs = 0.
  - With requests low, all m_* outputs are 0.
- Grants and m_* are combinational from requests, state and starve: zero-cycle accept.
- Read latency is exactly 1 cycle from grant to rvalid.
- Back-to-back reads from alternating requesters return in grant order, one per cycle.
- Reset asserted mid-read: the pending return is dropped; no rvalid after release.
- Requesters hold req, addr, we and wdata stable until gnt. Changing them while ungranted is legal and has no side effect.

## Test plan
- Fetch-only stream: f_req = 1 with f_addr = 0x0, 0x4, 0x8 and memory holding 0x11, 0x22, 0x33 -> f_gnt = 1 each cycle, f_rvalid from cycle 2, f_rdata = 0x11, 0x22, 0x33, m_addr = 0, 1, 2.
- Contention and starvation with STARVE_MAX = 4, f_req and d_req held high:
  - Fetch is granted 4 cycles, the loader is granted in cycle 5, then fetch again.
  - Pattern repeats every 5 cycles.
- Lock burst: loader writes 0xDEADBEEF to 0x100 and 0x104 with d_lock = 1 while f_req = 1 -> f_gnt = 0 during the burst; final write with d_lock = 0 returns to NORMAL and the next cycle grants fetch. Readback of 0x104 -> 0xDEADBEEF.
- Misaligned fetch f_addr = 0x6 -> f_gnt = 1, m_en = 0, next cycle f_rvalid = 1, f_err = 1, f_rdata = 0.
- Out-of-range loader write d_addr = 0x80000 -> d_gnt = 1, d_err = 1 in the same cycle, m_en = 0, memory unchanged.
- Reset mid-read: grant a fetch to 0x8, pull rst_n low before the next clock edge -> f_rvalid stays 0 and all outputs read their reset values.
